// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional divider datapath is built only when MDU_DIV_EN is defined.
module mdu_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // op[0]=0 selects the signed variants
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign a_neg = ~op[0] & A[31];
    assign b_neg = ~op[0] & B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;

    // Shift-add step: acc = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] mul_fix;

    assign mul_sum  = {1'b0, acc_q[63:32]}
                    + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_step = {mul_sum, acc_q[31:1]};
    assign mul_fix  = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;

    logic [63:0] div_step;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

`ifdef MDU_DIV_EN
    // Restoring step: acc = {partial remainder, dividend/quotient bits}
    logic [32:0] div_r;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_q;
    logic [31:0] div_rem;

    assign div_r    = {acc_q[63:32], acc_q[31]};
    assign div_diff = div_r - {1'b0, b_q};
    assign div_ge   = (div_r >= {1'b0, b_q});
    assign div_step = {div_ge ? div_diff[31:0] : div_r[31:0],
                       acc_q[30:0], div_ge};
    assign div_q    = acc_q[31:0];
    assign div_rem  = acc_q[63:32];
    // A zero divisor leaves the dividend in the remainder half,
    // so only the quotient needs overriding
    assign div_lo   = (b_q == 32'd0) ? 32'hFFFF_FFFF
                    : ((sa_q ^ sb_q) ? (~div_q + 32'd1) : div_q);
    assign div_hi   = sa_q ? (~div_rem + 32'd1) : div_rem;
`else
    assign div_step = 64'd0;
    assign div_hi   = 32'd0;
    assign div_lo   = 32'd0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state, iteration and HI/LO update logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hilo_we[1]) hi_d = wdata;
                if (hilo_we[0]) lo_d = wdata;
                if (start) begin
                    state_d = CALC;
                    op_d    = op;
                    cnt_d   = 6'd0;
                    acc_d   = {32'd0, a_mag};
                    b_d     = b_mag;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 6'd1;
                acc_d = op_q[1] ? div_step : mul_step;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end else begin
                    hi_d = mul_fix[63:32];
                    lo_d = mul_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rstn  input  1  asynchronous active-low reset.
REQ-003 start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 A, B  input  32 each  operands from the EX-stage operand latches that also feed the ALU; B is the divisor.
REQ-006 hilo_we  input  2  bit1 writes HI, bit0 writes LO from wdata (MTHI/MTLO).
REQ-007 wdata  input  32  data for hilo_we writes.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  registered one-cycle pulse when HI/LO hold a new result.
REQ-010 hi, lo  output  32 each  architectural HI/LO registers, read by the write-back mux (MFHI/MFLO).

Function
REQ-011 The FSM SHALL have states IDLE, CALC, FIX, with transitions IDLE->CALC on start, CALC->FIX after 32 iterations, and FIX->IDLE unconditionally.
REQ-012 In IDLE, start SHALL latch op plus the operand magnitudes (absolute values for signed ops, raw values for unsigned ops) and the sign flags, clear the 6-bit iteration counter, and set busy on the same edge.
REQ-013 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply (64-bit product), restoring shift-subtract for divide (33-bit partial remainder).
REQ-014 FIX SHALL apply sign correction, write the result to HI/LO, assert done for exactly one cycle, and clear busy on the same edge.
REQ-015 Latency SHALL be fixed: start sampled at edge N; done high and busy low in the cycle following edge N+33; the next start is accepted at edge N+34 or later.
REQ-016 Multiply SHALL write {hi,lo} as the full 64-bit product; for MULT, the product SHALL be negated when exactly one operand is negative.
REQ-017 Divide SHALL write lo as the quotient and hi as the remainder; for DIV, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of A.
REQ-018 Divide by zero SHALL complete with full latency and write lo=32'hFFFFFFFF, hi=A, for both DIV and DIVU.
REQ-019 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write lo=32'h80000000, hi=0.
REQ-020 start while busy SHALL be ignored, with no effect on the in-flight operation.
REQ-021 hilo_we in IDLE SHALL update the selected register(s) on the next edge; while busy it SHALL be ignored.
REQ-022 If hilo_we and start are asserted in the same IDLE cycle, the write SHALL take effect, the operation SHALL start, and the FIX result SHALL later overwrite HI/LO.
REQ-023 hi/lo SHALL change only on FIX or on an accepted hilo_we write, and SHALL hold all other times, including during CALC.

Reset
REQ-024 Asserting rstn low SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear internal datapath registers.
REQ-025 Reset mid-operation SHALL abort the operation with no partial result written; after reset release, the first edge with start=1 SHALL begin a fresh operation.

Configuration
REQ-026 Macro MDU_DIV_EN SHALL gate the divide datapath: when defined, DIV/DIVU behave per REQ-017 to REQ-019.
REQ-027 When MDU_DIV_EN is undefined, DIV/DIVU SHALL still follow the REQ-015 timing, write hi=0 and lo=0, and no divider logic SHALL be synthesized; multiply SHALL be unchanged.

Verification
REQ-028 MULT A=32'hFFFFFFFE (-2), B=3: done 34 cycles after start with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-029 MULTU A=B=32'hFFFFFFFF: hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-030 DIV A=-7, B=2: lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU A=7, B=0: lo=32'hFFFFFFFF, hi=7.
REQ-031 DIV A=32'h80000000, B=32'hFFFFFFFF: lo=32'h80000000, hi=0; with MDU_DIV_EN undefined, the same DIV gives hi=lo=0 at the same latency.
REQ-032 Start MULTU 5x6, pulse start with other operands at cycle 10 and hilo_we=2'b11 at cycle 20: result remains hi=0, lo=30, and only one done pulse occurs.
REQ-033 Start DIVU 100/7, drop rstn at cycle 15, release it, then run MULTU 3x4: no done before reset, hi=lo=0 after reset, and the final result is hi=0, lo=12.
